btb_ras_gen: RTL and testbench
==============================

Name: btb_ras_gen

Overview:
- Second-generation branch target buffer with a parametrised return address stack (RAS). It sits between IF and ID.
- IF presents the fetch PC and receives a registered prediction one cycle later. ID sends update, add and delete operations, and RAS push/pop requests.
- New relative to the previous generation:
  - parametrised entry count, tag width, counter width and RAS depth
  - duplicate-add merge
  - circular RAS with overwrite-on-full
  - RAS checkpoint/recovery on flush
  - global invalidate

Parameters:
- BTB_NUM, 16: number of entries, power of 2, 4..64.
- TAG_W, 10: PC bits [TAG_W+1:2] used as the tag.
- CNT_W, 2: saturating direction-counter width, at least 2.
- RAS_DEPTH, 8: number of RAS entries, power of 2.
- Derived: IDX_W=$clog2(BTB_NUM), RP_W=$clog2(RAS_DEPTH).

Ports:
- clk, in, 1: clock.
- resetn, in, 1: asynchronous active-low reset.
- fetch_en, in, 1: lookup strobe.
- fetch_pc, in, 32: PC being fetched.
- ret_en, out, 1: registered hit.
- taken, out, 1: counter MSB of the hit entry.
- ret_pc, out, 32: predicted target, low 2 bits 0.
- ret_index, out, IDX_W: index of the hit entry.
- ret_ras_ptr, out, RP_W: RAS pointer checkpoint taken at fetch.
- ret_ras_cnt, out, RP_W+1: RAS occupancy checkpoint taken at fetch.
- operate_en, in, 1: ID operation valid.
- operate_pc, in, 32: PC of the branch being resolved.
- operate_index, in, IDX_W: entry index carried from fetch.
- add_entry, delete_entry, target_error, pre_error, pre_right, in, 1 each: operation select.
- right_orien, in, 1: resolved direction.
- right_target, in, 32: resolved target.
- push_ras, pop_ras, in, 1 each: call / return (jirl).
- flush_all, in, 1: invalidate the whole BTB.
- recover_en, in, 1: restore the RAS checkpoint.
- recover_ptr, in, RP_W: checkpoint pointer to restore.
- recover_cnt, in, RP_W+1: checkpoint occupancy to restore.

Behaviour:
- Reset (async assert, sync deassert):
  - valid=0, jirl flags=0, match register=0.
  - ret_en=0, taken=0, ret_pc=0, ret_index=0.
  - RAS ptr=0, cnt=0, ret_ras_ptr=0, ret_ras_cnt=0.
  - LFSR=16'hACE1.
  - Tag, target and counter arrays are not reset.
- Lookup (1-cycle latency):
  - When fetch_en is high, register hit[i] = valid[i] && tag[i]==fetch_pc[TAG_W+1:2] && !(jirl[i] && cnt==0).
  - In the same cycle, register the RAS top and ptr/cnt.
  - fetch_en low holds all lookup outputs.
  - Multiple hits: the lowest index wins.
  - A table write in the same cycle is not visible; lookup reads the pre-write state.
- Outputs:
  - ret_pc = jirl ? {ras_top,2'b0} : {target,2'b0}.
  - taken = counter[CNT_W-1].
- Table ops when operate_en is high, priority order:
  1. flush_all: clear all valid bits and jirl flags.
  2. add_entry:
     - If the tag already matches a valid entry, update that entry in place (merge).
     - Otherwise choose the lowest invalid entry; if all entries are valid, choose LFSR[IDX_W-1:0].
     - Write tag, target=right_target[31:2], counter=weakly-taken (1<<(CNT_W-1)), jirl=pop_ras.
  3. delete_entry: valid[operate_index]=0, jirl[operate_index]=0.
  4. target_error && !pop_ras: at operate_index, target=right_target, counter=weakly-taken, jirl=0.
  5. pre_error or pre_right: saturating counter step at operate_index; increment if right_orien, else decrement. No wrap at 0 or max.
- flush_all is also honoured when operate_en is low.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
- RAS is a circular buffer. Ops are gated by operate_en; recover_en overrides them.
  - push only: write operate_pc[31:2]+1 at ptr, ptr++ with wrap, cnt=min(cnt+1, RAS_DEPTH). A push when full overwrites the oldest entry.
  - pop only, cnt>0: ptr--, cnt--. Pop when empty: no change.
  - push and pop together (tail call): overwrite the top slot (ptr-1); ptr and cnt unchanged. If cnt==0, treat as push only.
  - recover_en: ptr=recover_ptr, cnt=recover_cnt. Any same-cycle push/pop is ignored.
- Reset mid-operation discards any in-flight lookup: ret_en=0 on the following cycle.

Optional Feature:
- Macro BTB_PERF_CNT_EN.
- When defined, add output ports perf_lookup[31:0], perf_hit[31:0], perf_ras_ovf[15:0]:
  - perf_lookup increments on each fetch_en.
  - perf_hit increments on each registered hit.
  - perf_ras_ovf increments on each push while full.
  - All are free-running with wrap and reset to 0.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package btb_pkg:
  - weakly-taken constant function
  - LFSR seed and tap constants
  - op-priority encoding
  - RAS checkpoint struct {ptr, cnt}
- One sub-module: btb_ras_stack (RAS_DEPTH), owning push/pop/recover and the top read.

Test Plan:
- Add at pc 0x1C000100 with target 0x1C000200, then fetch 0x1C000100 -> next cycle ret_en=1, taken=1, ret_pc=0x1C000200.
- pre_error with right_orien=0 applied twice on that entry -> counter 10->01->00, taken=0. A third decrement holds 00. Three increments saturate at 11.
- Fill all 16 entries, then add one more -> the victim equals the LFSR low 4 bits. Re-add an existing tag -> no new slot is used; target is updated.
- Push 9 calls from pc 0x100..0x120 with depth 8 -> cnt=8 and the oldest is lost. 8 pops return 0x124,0x120,... The 9th pop leaves cnt 0 and ptr unchanged.
- Jirl entry with empty RAS -> ret_en=0. After a push from 0x400, the same fetch -> ret_pc=0x404.
- Checkpoint at fetch (ptr=3, cnt=3), then 2 pushes, then recover_en with the checkpoint -> ptr=3, cnt=3, top restored. flush_all -> all lookups miss.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer and its return address stack.
// Optional performance counters are enabled in btb_ras_gen by defining BTB_PERF_CNT_EN.
package btb_pkg;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5)
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  localparam int          RAS_PTR_MAX_W = 8;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_FLUSH = 3'd1,
    OP_ADD   = 3'd2,
    OP_DEL   = 3'd3,
    OP_TGT   = 3'd4,
    OP_CNT   = 3'd5
  } op_e;

  typedef struct packed {
    logic [RAS_PTR_MAX_W-1:0] ptr;
    logic [RAS_PTR_MAX_W:0]   cnt;
  } ras_ckpt_t;

  function automatic int unsigned weak_taken(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 32'd1);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

  // flush_all is honoured even without operate_en; everything else needs it
  function automatic op_e op_select(input logic operate_en, input logic flush_all,
                                    input logic add_entry, input logic delete_entry,
                                    input logic target_error, input logic pop_ras,
                                    input logic pre_error, input logic pre_right);
    op_e op;
    if (flush_all)                               op = OP_FLUSH;
    else if (!operate_en)                        op = OP_NONE;
    else if (add_entry)                          op = OP_ADD;
    else if (delete_entry)                       op = OP_DEL;
    else if (target_error && !pop_ras)           op = OP_TGT;
    else if (pre_error || pre_right)             op = OP_CNT;
    else                                         op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/btb_ras_stack.sv
// Circular return address stack with overwrite-on-full, tail-call replace and
// checkpoint recovery. Stores word addresses (PC[31:2]).
module btb_ras_stack
  import btb_pkg::*;
#(
  parameter  int RAS_DEPTH = 8,
  localparam int RP_W      = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_en_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [29:0]     push_val_i,
  input  logic            recover_en_i,
  input  logic [RP_W-1:0] recover_ptr_i,
  input  logic [RP_W:0]   recover_cnt_i,
  output logic [RP_W-1:0] ptr_o,
  output logic [RP_W:0]   cnt_o,
  output logic [29:0]     top_o,
  output logic            ovf_o
);

  localparam logic [RP_W:0] FULL = (RP_W+1)'(RAS_DEPTH);

  logic [29:0]     mem_q [RAS_DEPTH];
  logic [RP_W-1:0] ptr_q, ptr_d, top_ptr_s, wr_ptr_s;
  logic [RP_W:0]   cnt_q, cnt_d;
  logic            wr_en_s;

  assign top_ptr_s = ptr_q - RP_W'(1);

  // Next pointer/occupancy and write slot; recovery overrides push/pop
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_ptr_s = ptr_q;
    ovf_o    = 1'b0;
    if (recover_en_i) begin
      ptr_d = recover_ptr_i;
      cnt_d = recover_cnt_i;
    end else if (op_en_i && push_i && pop_i && (cnt_q != '0)) begin
      wr_en_s  = 1'b1;
      wr_ptr_s = top_ptr_s;
    end else if (op_en_i && push_i) begin
      wr_en_s = 1'b1;
      ptr_d   = ptr_q + RP_W'(1);
      cnt_d   = (cnt_q == FULL) ? cnt_q : cnt_q + (RP_W+1)'(1);
      ovf_o   = (cnt_q == FULL);
    end else if (op_en_i && pop_i && (cnt_q != '0)) begin
      ptr_d = top_ptr_s;
      cnt_d = cnt_q - (RP_W+1)'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage, not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_s] <= push_val_i;
  end

  assign ptr_o = ptr_q;
  assign cnt_o = cnt_q;
  assign top_o = mem_q[top_ptr_s];

endmodule

// File: rtl/btb_ras_gen.sv
// Branch target buffer with return address stack between IF and ID; one-cycle lookup.
// Define BTB_PERF_CNT_EN to add perf_lookup/perf_hit/perf_ras_ovf counter outputs.
module btb_ras_gen
  import btb_pkg::*;
#(
  parameter  int BTB_NUM   = 16,
  parameter  int TAG_W     = 10,
  parameter  int CNT_W     = 2,
  parameter  int RAS_DEPTH = 8,
  localparam int IDX_W     = $clog2(BTB_NUM),
  localparam int RP_W      = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0]      perf_lookup,
  output logic [31:0]      perf_hit,
  output logic [15:0]      perf_ras_ovf,
`endif
  input  logic             resetn,
  input  logic             fetch_en,
  input  logic [31:0]      fetch_pc,
  output logic             ret_en,
  output logic             taken,
  output logic [31:0]      ret_pc,
  output logic [IDX_W-1:0] ret_index,
  output logic [RP_W-1:0]  ret_ras_ptr,
  output logic [RP_W:0]    ret_ras_cnt,
  input  logic             operate_en,
  input  logic [31:0]      operate_pc,
  input  logic [IDX_W-1:0] operate_index,
  input  logic             add_entry,
  input  logic             delete_entry,
  input  logic             target_error,
  input  logic             pre_error,
  input  logic             pre_right,
  input  logic             right_orien,
  input  logic [31:0]      right_target,
  input  logic             push_ras,
  input  logic             pop_ras,
  input  logic             flush_all,
  input  logic             recover_en,
  input  logic [RP_W-1:0]  recover_ptr,
  input  logic [RP_W:0]    recover_cnt
);

  localparam logic [CNT_W-1:0] WEAK = CNT_W'(weak_taken(CNT_W));

  logic [BTB_NUM-1:0] valid_q, valid_d, jirl_q, jirl_d, match_q;
  logic [TAG_W-1:0]   tag_q [BTB_NUM];
  logic [29:0]        tgt_q [BTB_NUM];
  logic [CNT_W-1:0]   ctr_q [BTB_NUM];
  logic [15:0]        lfsr_q;
  ras_ckpt_t          ckpt_q;
  logic               ret_en_q, taken_q;
  logic [31:0]        ret_pc_q;
  logic [IDX_W-1:0]   ret_index_q;

  logic [BTB_NUM-1:0] hit_s, add_match_s;
  logic [IDX_W-1:0]   hit_idx_s, merge_idx_s, free_idx_s, add_idx_s, wr_idx_s;
  logic               wr_tag_en_s, wr_tgt_en_s, wr_ctr_en_s;
  logic [CNT_W-1:0]   ctr_cur_s, ctr_wdata_s;
  op_e                op_s;
  logic [RP_W-1:0]    ras_ptr_s;
  logic [RP_W:0]      ras_cnt_s;
  logic [29:0]        ras_top_s;
  logic               ras_ovf_s;

  btb_ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk          (clk),
    .resetn       (resetn),
    .op_en_i      (operate_en),
    .push_i       (push_ras),
    .pop_i        (pop_ras),
    .push_val_i   (operate_pc[31:2] + 30'd1),
    .recover_en_i (recover_en),
    .recover_ptr_i(recover_ptr),
    .recover_cnt_i(recover_cnt),
    .ptr_o        (ras_ptr_s),
    .cnt_o        (ras_cnt_s),
    .top_o        (ras_top_s),
    .ovf_o        (ras_ovf_s)
  );

  // Fetch-side and ID-side tag compares; a jirl entry cannot hit with an empty RAS
  always_comb begin
    hit_s       = '0;
    add_match_s = '0;
    for (int i = 0; i < BTB_NUM; i++) begin
      hit_s[i]       = valid_q[i] && (tag_q[i] == fetch_pc[TAG_W+1:2]) &&
                       !(jirl_q[i] && (ras_cnt_s == '0));
      add_match_s[i] = valid_q[i] && (tag_q[i] == operate_pc[TAG_W+1:2]);
    end
  end

  // Lowest-index priority encoders and add-victim choice
  always_comb begin
    hit_idx_s   = '0;
    merge_idx_s = '0;
    free_idx_s  = '0;
    for (int i = BTB_NUM - 1; i >= 0; i--) begin
      hit_idx_s   = hit_s[i]       ? IDX_W'(i) : hit_idx_s;
      merge_idx_s = add_match_s[i] ? IDX_W'(i) : merge_idx_s;
      free_idx_s  = !valid_q[i]    ? IDX_W'(i) : free_idx_s;
    end
    if (|add_match_s)     add_idx_s = merge_idx_s;
    else if (!(&valid_q)) add_idx_s = free_idx_s;
    else                  add_idx_s = lfsr_q[IDX_W-1:0];
  end

  assign op_s      = op_select(operate_en, flush_all, add_entry, delete_entry,
                               target_error, pop_ras, pre_error, pre_right);
  assign ctr_cur_s = ctr_q[operate_index];

  // Table update decode
  always_comb begin
    valid_d     = valid_q;
    jirl_d      = jirl_q;
    wr_idx_s    = operate_index;
    wr_tag_en_s = 1'b0;
    wr_tgt_en_s = 1'b0;
    wr_ctr_en_s = 1'b0;
    ctr_wdata_s = WEAK;
    case (op_s)
      OP_FLUSH: begin
        valid_d = '0;
        jirl_d  = '0;
      end
      OP_ADD: begin
        wr_idx_s           = add_idx_s;
        valid_d[add_idx_s] = 1'b1;
        jirl_d[add_idx_s]  = pop_ras;
        wr_tag_en_s        = 1'b1;
        wr_tgt_en_s        = 1'b1;
        wr_ctr_en_s        = 1'b1;
      end
      OP_DEL: begin
        valid_d[operate_index] = 1'b0;
        jirl_d[operate_index]  = 1'b0;
      end
      OP_TGT: begin
        jirl_d[operate_index] = 1'b0;
        wr_tgt_en_s           = 1'b1;
        wr_ctr_en_s           = 1'b1;
      end
      OP_CNT: begin
        wr_ctr_en_s = 1'b1;
        ctr_wdata_s = right_orien ? ((&ctr_cur_s)  ? ctr_cur_s : ctr_cur_s + CNT_W'(1))
                                  : ((|ctr_cur_s)  ? ctr_cur_s - CNT_W'(1) : ctr_cur_s);
      end
      default: begin
        valid_d = valid_q;
        jirl_d  = jirl_q;
      end
    endcase
  end

  // Valid/jirl flags and victim LFSR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      jirl_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      valid_q <= valid_d;
      jirl_q  <= jirl_d;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  // Entry payload arrays, not reset
  always_ff @(posedge clk) begin
    if (wr_tag_en_s) tag_q[wr_idx_s] <= operate_pc[TAG_W+1:2];
    if (wr_tgt_en_s) tgt_q[wr_idx_s] <= right_target[31:2];
    if (wr_ctr_en_s) ctr_q[wr_idx_s] <= ctr_wdata_s;
  end

  // Registered prediction and RAS checkpoint; held while fetch_en is low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      match_q     <= '0;
      ret_en_q    <= 1'b0;
      taken_q     <= 1'b0;
      ret_pc_q    <= '0;
      ret_index_q <= '0;
      ckpt_q      <= '0;
    end else if (fetch_en) begin
      match_q     <= hit_s;
      ret_en_q    <= |hit_s;
      taken_q     <= (|hit_s) & ctr_q[hit_idx_s][CNT_W-1];
      ret_pc_q    <= !(|hit_s)          ? 32'd0 :
                     jirl_q[hit_idx_s]  ? {ras_top_s, 2'b00} : {tgt_q[hit_idx_s], 2'b00};
      ret_index_q <= hit_idx_s;
      ckpt_q.ptr  <= RAS_PTR_MAX_W'(ras_ptr_s);
      ckpt_q.cnt  <= (RAS_PTR_MAX_W+1)'(ras_cnt_s);
    end
  end

  assign ret_en      = ret_en_q;
  assign taken       = taken_q;
  assign ret_pc      = ret_pc_q;
  assign ret_index   = ret_index_q;
  assign ret_ras_ptr = ckpt_q.ptr[RP_W-1:0];
  assign ret_ras_cnt = ckpt_q.cnt[RP_W:0];

`ifdef BTB_PERF_CNT_EN
  logic [31:0] perf_lookup_q, perf_hit_q;
  logic [15:0] perf_ras_ovf_q;

  // Free-running event counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lookup_q  <= 32'd0;
      perf_hit_q     <= 32'd0;
      perf_ras_ovf_q <= 16'd0;
    end else begin
      if (fetch_en)            perf_lookup_q  <= perf_lookup_q + 32'd1;
      if (fetch_en && |hit_s)  perf_hit_q     <= perf_hit_q + 32'd1;
      if (ras_ovf_s)           perf_ras_ovf_q <= perf_ras_ovf_q + 16'd1;
    end
  end

  assign perf_lookup  = perf_lookup_q;
  assign perf_hit     = perf_hit_q;
  assign perf_ras_ovf = perf_ras_ovf_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = ras_ovf_s;
`endif

  logic unused_s;
  assign unused_s = ^{fetch_pc[31:TAG_W+2], fetch_pc[1:0], operate_pc[1:0],
                      right_target[1:0], match_q, ckpt_q};

endmodule

// File: tb/tb_btb_ras_gen.sv
// Directed self-checking bench for btb_ras_gen (default parameters).
`timescale 1ns/1ps
module tb_btb_ras_gen;

  localparam int IDX_W = 4;
  localparam int RP_W  = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             fetch_en;
  logic [31:0]      fetch_pc;
  logic             ret_en, taken;
  logic [31:0]      ret_pc;
  logic [IDX_W-1:0] ret_index;
  logic [RP_W-1:0]  ret_ras_ptr;
  logic [RP_W:0]    ret_ras_cnt;
  logic             operate_en;
  logic [31:0]      operate_pc;
  logic [IDX_W-1:0] operate_index;
  logic             add_entry, delete_entry, target_error, pre_error, pre_right;
  logic             right_orien;
  logic [31:0]      right_target;
  logic             push_ras, pop_ras, flush_all, recover_en;
  logic [RP_W-1:0]  recover_ptr;
  logic [RP_W:0]    recover_cnt;
`ifdef BTB_PERF_CNT_EN
  logic [31:0]      perf_lookup, perf_hit;
  logic [15:0]      perf_ras_ovf;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  victim, k_idx;
  logic [31:0] pc_k;

  localparam logic [31:0] JPC = 32'h1C00_0500;

  btb_ras_gen dut (
    .clk          (clk),
`ifdef BTB_PERF_CNT_EN
    .perf_lookup  (perf_lookup),
    .perf_hit     (perf_hit),
    .perf_ras_ovf (perf_ras_ovf),
`endif
    .resetn       (resetn),
    .fetch_en     (fetch_en),
    .fetch_pc     (fetch_pc),
    .ret_en       (ret_en),
    .taken        (taken),
    .ret_pc       (ret_pc),
    .ret_index    (ret_index),
    .ret_ras_ptr  (ret_ras_ptr),
    .ret_ras_cnt  (ret_ras_cnt),
    .operate_en   (operate_en),
    .operate_pc   (operate_pc),
    .operate_index(operate_index),
    .add_entry    (add_entry),
    .delete_entry (delete_entry),
    .target_error (target_error),
    .pre_error    (pre_error),
    .pre_right    (pre_right),
    .right_orien  (right_orien),
    .right_target (right_target),
    .push_ras     (push_ras),
    .pop_ras      (pop_ras),
    .flush_all    (flush_all),
    .recover_en   (recover_en),
    .recover_ptr  (recover_ptr),
    .recover_cnt  (recover_cnt)
  );

  always #5 clk = ~clk;

  // Reference victim-selection LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    operate_en = 1'b0; operate_pc = 32'd0; operate_index = '0;
    add_entry = 1'b0; delete_entry = 1'b0; target_error = 1'b0;
    pre_error = 1'b0; pre_right = 1'b0; right_orien = 1'b0; right_target = 32'd0;
    push_ras = 1'b0; pop_ras = 1'b0; flush_all = 1'b0;
    recover_en = 1'b0; recover_ptr = '0; recover_cnt = '0;
  endtask

  task automatic op_add(input logic [31:0] pc, input logic [31:0] tgt, input logic jirl);
    operate_en = 1'b1; add_entry = 1'b1; operate_pc = pc; right_target = tgt; pop_ras = jirl;
    tick(); idle();
  endtask

  task automatic op_ctr(input logic [IDX_W-1:0] idx, input logic dir);
    operate_en = 1'b1; pre_error = 1'b1; operate_index = idx; right_orien = dir;
    tick(); idle();
  endtask

  task automatic ras(input logic push, input logic pop, input logic [31:0] pc);
    operate_en = 1'b1; push_ras = push; pop_ras = pop; operate_pc = pc;
    tick(); idle();
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_en = 1'b1; fetch_pc = pc;
    tick();
    fetch_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b1; fetch_en = 1'b0; fetch_pc = 32'd0; idle();
    #2 resetn = 1'b0;
    tick(); tick();
    chk("rst_ret_en", 32'(ret_en), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_ret_pc", ret_pc, 32'd0);
    chk("rst_index", 32'(ret_index), 32'd0);
    chk("rst_ras_ptr", 32'(ret_ras_ptr), 32'd0);
    chk("rst_ras_cnt", 32'(ret_ras_cnt), 32'd0);
    resetn = 1'b1;
    tick();

    // basic add + lookup
    op_add(32'h1C00_0100, 32'h1C00_0200, 1'b0);
    fetch(32'h1C00_0100);
    chk("hit_en", 32'(ret_en), 32'd1);
    chk("hit_taken", 32'(taken), 32'd1);
    chk("hit_pc", ret_pc, 32'h1C00_0200);
    chk("hit_index", 32'(ret_index), 32'd0);

    // same-cycle add is invisible to the lookup
    operate_en = 1'b1; add_entry = 1'b1; operate_pc = 32'h1C00_0300; right_target = 32'h1C00_0600;
    fetch_en = 1'b1; fetch_pc = 32'h1C00_0300;
    tick(); idle(); fetch_en = 1'b0;
    chk("same_cycle_miss", 32'(ret_en), 32'd0);
    fetch(32'h1C00_0300);
    chk("second_hit_en", 32'(ret_en), 32'd1);
    chk("second_hit_pc", ret_pc, 32'h1C00_0600);
    chk("second_hit_idx", 32'(ret_index), 32'd1);

    // saturating counter on entry 0
    op_ctr(4'd0, 1'b0); op_ctr(4'd0, 1'b0);
    fetch(32'h1C00_0100);
    chk("ctr_00_taken", 32'(taken), 32'd0);
    op_ctr(4'd0, 1'b0); op_ctr(4'd0, 1'b1);
    fetch(32'h1C00_0100);
    chk("ctr_hold_low", 32'(taken), 32'd0);
    op_ctr(4'd0, 1'b1); op_ctr(4'd0, 1'b1); op_ctr(4'd0, 1'b1); op_ctr(4'd0, 1'b0);
    fetch(32'h1C00_0100);
    chk("ctr_hold_high", 32'(taken), 32'd1);

    // target_error rewrites target and resets counter to weakly taken
    op_ctr(4'd0, 1'b0);
    operate_en = 1'b1; target_error = 1'b1; operate_index = 4'd0; right_target = 32'h1C00_0480;
    tick(); idle();
    fetch(32'h1C00_0100);
    chk("tgt_err_pc", ret_pc, 32'h1C00_0480);
    chk("tgt_err_taken", 32'(taken), 32'd1);

    // jirl entry needs a non-empty RAS
    op_add(JPC, 32'd0, 1'b1);
    fetch(JPC);
    chk("jirl_empty_miss", 32'(ret_en), 32'd0);
    ras(1'b1, 1'b0, 32'h0000_0400);
    fetch(JPC);
    chk("jirl_hit_en", 32'(ret_en), 32'd1);
    chk("jirl_hit_pc", ret_pc, 32'h0000_0404);
    chk("jirl_hit_idx", 32'(ret_index), 32'd2);
    chk("jirl_ptr", 32'(ret_ras_ptr), 32'd1);
    chk("jirl_cnt", 32'(ret_ras_cnt), 32'd1);
    ras(1'b0, 1'b1, 32'd0);

    // RAS overflow: 9 pushes into depth 8
    for (int i = 0; i < 9; i++) ras(1'b1, 1'b0, 32'h100 + 32'(4 * i));
    fetch(JPC);
    chk("ovf_cnt", 32'(ret_ras_cnt), 32'd8);
    chk("ovf_ptr", 32'(ret_ras_ptr), 32'd1);
    for (int k = 0; k < 8; k++) begin
      fetch_en = 1'b1; fetch_pc = JPC; operate_en = 1'b1; pop_ras = 1'b1;
      tick(); idle(); fetch_en = 1'b0;
      chk($sformatf("pop_%0d", k), ret_pc, 32'h124 - 32'(4 * k));
    end
    fetch(JPC);
    chk("drained_miss", 32'(ret_en), 32'd0);
    chk("drained_cnt", 32'(ret_ras_cnt), 32'd0);
    ras(1'b0, 1'b1, 32'd0);
    fetch(JPC);
    chk("empty_pop_cnt", 32'(ret_ras_cnt), 32'd0);
    chk("empty_pop_ptr", 32'(ret_ras_ptr), 32'd1);

    // checkpoint and recovery
    recover_en = 1'b1; recover_ptr = 3'd0; recover_cnt = 4'd0;
    tick(); idle();
    ras(1'b1, 1'b0, 32'h600); ras(1'b1, 1'b0, 32'h604); ras(1'b1, 1'b0, 32'h608);
    fetch(JPC);
    chk("ckpt_ptr", 32'(ret_ras_ptr), 32'd3);
    chk("ckpt_cnt", 32'(ret_ras_cnt), 32'd3);
    chk("ckpt_top", ret_pc, 32'h60C);
    ras(1'b1, 1'b0, 32'h700); ras(1'b1, 1'b0, 32'h704);
    fetch(JPC);
    chk("spec_top", ret_pc, 32'h708);
    chk("spec_cnt", 32'(ret_ras_cnt), 32'd5);
    recover_en = 1'b1; recover_ptr = 3'd3; recover_cnt = 4'd3;
    operate_en = 1'b1; push_ras = 1'b1; operate_pc = 32'h900;
    tick(); idle();
    fetch(JPC);
    chk("rec_ptr", 32'(ret_ras_ptr), 32'd3);
    chk("rec_cnt", 32'(ret_ras_cnt), 32'd3);
    chk("rec_top", ret_pc, 32'h60C);

    // tail call replaces the top slot
    ras(1'b1, 1'b1, 32'h800);
    fetch(JPC);
    chk("tail_top", ret_pc, 32'h804);
    chk("tail_ptr", 32'(ret_ras_ptr), 32'd3);
    chk("tail_cnt", 32'(ret_ras_cnt), 32'd3);

    // flush without operate_en
    flush_all = 1'b1; tick(); idle();
    fetch(32'h1C00_0100);
    chk("flush_miss_a", 32'(ret_en), 32'd0);
    fetch(JPC);
    chk("flush_miss_j", 32'(ret_en), 32'd0);

    // fill all 16 entries, then LFSR victim and merge
    for (int i = 0; i < 16; i++) op_add(32'h2000_0000 + 32'(4 * i), 32'h3000_0000 + 32'(16 * i), 1'b0);
    fetch(32'h2000_003C);
    chk("fill_idx15", 32'(ret_index), 32'd15);
    chk("fill_pc15", ret_pc, 32'h3000_00F0);
    operate_en = 1'b1; add_entry = 1'b1; operate_pc = 32'h2000_0040; right_target = 32'h3FFF_0000;
    victim = m_lfsr[3:0];
    tick(); idle();
    fetch(32'h2000_0040);
    chk("victim_hit", 32'(ret_en), 32'd1);
    chk("victim_idx", 32'(ret_index), 32'(victim));
    chk("victim_pc", ret_pc, 32'h3FFF_0000);
    fetch(32'h2000_0000 + {26'd0, victim, 2'b00});
    chk("victim_old_miss", 32'(ret_en), 32'd0);
    k_idx = victim + 4'd1;
    pc_k  = 32'h2000_0000 + {26'd0, k_idx, 2'b00};
    op_add(pc_k, 32'h3ABC_0000, 1'b0);
    fetch(pc_k);
    chk("merge_idx", 32'(ret_index), 32'(k_idx));
    chk("merge_pc", ret_pc, 32'h3ABC_0000);
    fetch(32'h2000_0040);
    chk("merge_no_slot", 32'(ret_index), 32'(victim));
    chk("merge_no_slot_en", 32'(ret_en), 32'd1);

    // reset mid-lookup discards the in-flight prediction
    fetch_en = 1'b1; fetch_pc = 32'h2000_0040;
    #3 resetn = 1'b0;
    #1;
    chk("midrst_ret_en", 32'(ret_en), 32'd0);
    tick(); tick();
    resetn = 1'b1; fetch_en = 1'b0;
    fetch(32'h2000_0040);
    chk("postrst_miss", 32'(ret_en), 32'd0);
    chk("postrst_cnt", 32'(ret_ras_cnt), 32'd0);

    // flush outranks a same-cycle add
    op_add(32'h1C00_0100, 32'h1C00_0200, 1'b0);
    operate_en = 1'b1; add_entry = 1'b1; flush_all = 1'b1;
    operate_pc = 32'h1C00_0700; right_target = 32'h1C00_0900;
    tick(); idle();
    fetch(32'h1C00_0100);
    chk("flush_prio_old", 32'(ret_en), 32'd0);
    fetch(32'h1C00_0700);
    chk("flush_prio_new", 32'(ret_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
